// File: rtl/audio_pll_ctrl.sv
// Audio PLL bring-up sequencer: resets the PLL, waits for a synchronized lock,
// qualifies it for a stable period, retries on timeout and latches a fault when retries run out.
module audio_pll_ctrl #(
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 125000,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       enable,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       clk_ok,
  output logic       busy,
  output logic       fault,
  output logic [7:0] lock_loss_cnt,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_OFF       = 3'd0,
    S_RESET     = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_STABLE    = 3'd3,
    S_RUN       = 3'd4,
    S_FAULT     = 3'd5
  } state_t;

  localparam logic [19:0] RST_LAST     = 20'(RST_CYCLES - 1);
  localparam logic [19:0] STABLE_LAST  = 20'(STABLE_CYCLES - 1);
  localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]  RETRY_MAX    = 3'(MAX_RETRIES);

  state_t      cur_state, nxt_state;
  logic [19:0] cnt, cnt_nxt;
  logic [2:0]  retry, retry_nxt;
  logic        sync_ff, locked_s;
  logic        loss_evt;

  always_ff @(posedge refclk) begin
    if (rst) begin
      sync_ff  <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync_ff  <= pll_locked;
      locked_s <= sync_ff;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    retry_nxt = retry;
    cnt_nxt   = cnt + 20'd1;
    case (cur_state)
      S_OFF: begin
        cnt_nxt = '0;
        if (enable) begin
          nxt_state = S_RESET;
          retry_nxt = '0;
        end
      end
      S_RESET: begin
        if (cnt == RST_LAST) nxt_state = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (locked_s) begin
          nxt_state = S_STABLE;
        end else if (cnt == TIMEOUT_LAST) begin
          if (retry < RETRY_MAX) begin
            nxt_state = S_RESET;
            retry_nxt = retry + 3'd1;
          end else begin
            nxt_state = S_FAULT;
          end
        end
      end
      S_STABLE: begin
        if (!locked_s) begin
          nxt_state = S_WAIT_LOCK;
        end else if (cnt == STABLE_LAST) begin
          nxt_state = S_RUN;
          retry_nxt = '0;
        end
      end
      S_RUN: begin
        cnt_nxt = '0;
        if (!locked_s) nxt_state = S_RESET;
      end
      S_FAULT: begin
        cnt_nxt = '0;
      end
      default: begin
        nxt_state = S_OFF;
      end
    endcase
    // Dropping enable wins over every timed or lock-driven transition.
    if (!enable) nxt_state = S_OFF;
    if (nxt_state != cur_state) cnt_nxt = '0;
  end

  assign loss_evt = (cur_state == S_RUN) && !locked_s;

  always_ff @(posedge refclk) begin
    if (rst) begin
      cur_state     <= S_OFF;
      cnt           <= '0;
      retry         <= '0;
      lock_loss_cnt <= '0;
      pll_rst       <= 1'b1;
      clk_ok        <= 1'b0;
      busy          <= 1'b0;
      fault         <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      cnt       <= cnt_nxt;
      retry     <= retry_nxt;
      if (loss_evt && lock_loss_cnt != 8'hFF) lock_loss_cnt <= lock_loss_cnt + 8'd1;
      // Outputs are decoded from the next state so they align with the state register.
      pll_rst <= (nxt_state == S_OFF) || (nxt_state == S_RESET) || (nxt_state == S_FAULT);
      clk_ok  <= (nxt_state == S_RUN);
      busy    <= (nxt_state == S_RESET) || (nxt_state == S_WAIT_LOCK) || (nxt_state == S_STABLE);
      fault   <= (nxt_state == S_FAULT);
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_audio_pll_ctrl.sv
// Directed bench for audio_pll_ctrl with short timing parameters.
module tb_audio_pll_ctrl;

  logic       refclk = 1'b0;
  logic       rst, enable, pll_locked;
  logic       pll_rst, clk_ok, busy, fault;
  logic [7:0] lock_loss_cnt;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  audio_pll_ctrl #(
    .RST_CYCLES(4), .STABLE_CYCLES(8), .TIMEOUT_CYCLES(32), .MAX_RETRIES(2)
  ) dut (
    .refclk(refclk), .rst(rst), .enable(enable), .pll_locked(pll_locked),
    .pll_rst(pll_rst), .clk_ok(clk_ok), .busy(busy), .fault(fault),
    .lock_loss_cnt(lock_loss_cnt), .state(state)
  );

  always #5 refclk = ~refclk;

  typedef struct {
    logic       en;
    logic       lk;
    int         n;
    logic [2:0] st;
    logic [7:0] loss;
  } vec_t;

  vec_t tbl[21];

  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  // {state, pll_rst, clk_ok, busy, fault, lock_loss_cnt}
  function automatic logic [14:0] exp_vec(logic [2:0] st, logic [7:0] loss);
    logic [3:0] o;
    case (st)
      3'd0:    o = 4'b1000;
      3'd1:    o = 4'b1010;
      3'd2:    o = 4'b0010;
      3'd3:    o = 4'b0010;
      3'd4:    o = 4'b0100;
      3'd5:    o = 4'b1001;
      default: o = 4'bxxxx;
    endcase
    return {st, o, loss};
  endfunction

  function automatic logic [14:0] obs();
    return {state, pll_rst, clk_ok, busy, fault, lock_loss_cnt};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Steps until state matches, up to budget cycles; the final compare covers an expired bound.
  task automatic wait_state(input logic [2:0] target, input int budget, input string name, output bit ok);
    for (int k = 0; k < budget && state != target; k++) step();
    ok = (state == target);
    chk(name, 32'(state), 32'(target));
  endtask

  initial begin
    bit       ok;
    bit       seen_ok;
    logic [2:0] es;

    tbl[0]  = '{1'b1, 1'b0, 1, 3'd1, 8'd0};
    tbl[1]  = '{1'b1, 1'b0, 3, 3'd1, 8'd0};
    tbl[2]  = '{1'b1, 1'b0, 1, 3'd2, 8'd0};
    tbl[3]  = '{1'b1, 1'b0, 5, 3'd2, 8'd0};
    tbl[4]  = '{1'b1, 1'b1, 2, 3'd2, 8'd0};
    tbl[5]  = '{1'b1, 1'b1, 1, 3'd3, 8'd0};
    tbl[6]  = '{1'b1, 1'b1, 7, 3'd3, 8'd0};
    tbl[7]  = '{1'b1, 1'b1, 1, 3'd4, 8'd0};
    tbl[8]  = '{1'b1, 1'b0, 2, 3'd4, 8'd0};
    tbl[9]  = '{1'b1, 1'b0, 1, 3'd1, 8'd1};
    tbl[10] = '{1'b1, 1'b0, 3, 3'd1, 8'd1};
    tbl[11] = '{1'b1, 1'b0, 1, 3'd2, 8'd1};
    tbl[12] = '{1'b1, 1'b1, 3, 3'd3, 8'd1};
    tbl[13] = '{1'b1, 1'b1, 2, 3'd3, 8'd1};
    tbl[14] = '{1'b1, 1'b0, 2, 3'd3, 8'd1};
    tbl[15] = '{1'b1, 1'b0, 1, 3'd2, 8'd1};
    tbl[16] = '{1'b1, 1'b1, 2, 3'd2, 8'd1};
    tbl[17] = '{1'b1, 1'b1, 1, 3'd3, 8'd1};
    tbl[18] = '{1'b1, 1'b1, 7, 3'd3, 8'd1};
    tbl[19] = '{1'b1, 1'b1, 1, 3'd4, 8'd1};
    tbl[20] = '{1'b0, 1'b1, 1, 3'd0, 8'd1};

    rst = 1'b1; enable = 1'b0; pll_locked = 1'b0;
    repeat (3) step();
    chk("reset_state", 32'(obs()), 32'(exp_vec(3'd0, 8'd0)));
    rst = 1'b0;
    step();
    chk("off_idle", 32'(obs()), 32'(exp_vec(3'd0, 8'd0)));

    // Nominal lock, lock loss in RUN, glitch in STABLE, then enable drop from RUN.
    for (int i = 0; i < 21; i++) begin
      enable     = tbl[i].en;
      pll_locked = tbl[i].lk;
      repeat (tbl[i].n) step();
      chk($sformatf("vec%0d", i), 32'(obs()), 32'(exp_vec(tbl[i].st, tbl[i].loss)));
    end

    // Drive many lock losses to saturate the counter.
    enable = 1'b1;
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b1;
      wait_state(3'd4, 200, "sat_reach_run", ok);
      if (!ok) break;
      pll_locked = 1'b0;
      wait_state(3'd1, 50, "sat_reach_reset", ok);
      if (!ok) break;
      if (i == 9) chk("loss_cnt_11", 32'(lock_loss_cnt), 32'd11);
    end
    chk("loss_cnt_sat", 32'(lock_loss_cnt), 32'd255);

    // rst in WAIT_LOCK clears everything including the loss counter.
    wait_state(3'd2, 20, "reach_wait", ok);
    rst = 1'b1;
    step();
    chk("rst_in_wait", 32'(obs()), 32'(exp_vec(3'd0, 8'd0)));
    rst = 1'b0; enable = 1'b0;
    step();

    // Timeout path: three reset pulses separated by 32-cycle waits, then FAULT.
    enable = 1'b1;
    for (int e = 1; e <= 112; e++) begin
      step();
      if      (e <= 4)   es = 3'd1;
      else if (e <= 36)  es = 3'd2;
      else if (e <= 40)  es = 3'd1;
      else if (e <= 72)  es = 3'd2;
      else if (e <= 76)  es = 3'd1;
      else if (e <= 108) es = 3'd2;
      else               es = 3'd5;
      chk($sformatf("timeout_e%0d", e), 32'(obs()), 32'(exp_vec(es, 8'd0)));
    end
    enable = 1'b0;
    step();
    chk("fault_clear", 32'(obs()), 32'(exp_vec(3'd0, 8'd0)));

    // enable drop on the terminal STABLE cycle must win over the move to RUN.
    enable = 1'b1; pll_locked = 1'b1;
    seen_ok = 1'b0;
    for (int k = 0; k < 20 && state != 3'd3; k++) begin
      step();
      seen_ok |= clk_ok;
    end
    chk("prio_reach_stable", 32'(state), 32'd3);
    for (int k = 0; k < 7; k++) begin
      step();
      seen_ok |= clk_ok;
    end
    chk("prio_stable_last", 32'(state), 32'd3);
    enable = 1'b0;
    step();
    seen_ok |= clk_ok;
    chk("prio_off", 32'(obs()), 32'(exp_vec(3'd0, 8'd0)));
    step();
    seen_ok |= clk_ok;
    chk("prio_no_clk_ok", 32'(seen_ok), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_pll_ctrl.md
AUDIO_PLL_CTRL -- requirements
Module: audio_pll_ctrl

Interface
- REQ-001: The block SHALL have parameter RST_CYCLES, default 16: cycles pll_rst is held high per reset attempt (range 1..65535).
- REQ-002: The block SHALL have parameter STABLE_CYCLES, default 1024: cycles of continuous synchronized lock required before the clock is declared usable (range 1..65535).
- REQ-003: The block SHALL have parameter TIMEOUT_CYCLES, default 125000: cycles to wait for lock per attempt (1 ms at 125 MHz; range 1..2^20-1).
- REQ-004: The block SHALL have parameter MAX_RETRIES, default 3: number of additional reset attempts after the first timeout (range 0..7).
- REQ-005: The block SHALL have the port refclk, input, 1 bit: the single clock, 125 MHz PLL reference domain.
- REQ-006: The block SHALL have the port rst, input, 1 bit: synchronous, active-high reset.
- REQ-007: The block SHALL have the port enable, input, 1 bit: request for a running audio clock (level).
- REQ-008: The block SHALL have the port pll_locked, input, 1 bit: raw PLL lock indication, asynchronous to refclk.
- REQ-009: The block SHALL have the port pll_rst, output, 1 bit: reset to the audio PLL, active high.
- REQ-010: The block SHALL have the port clk_ok, output, 1 bit: the 24.576 MHz audio clock is locked and stable, and the codec may run.
- REQ-011: The block SHALL have the port busy, output, 1 bit: a lock sequence is in progress.
- REQ-012: The block SHALL have the port fault, output, 1 bit: retries are exhausted (sticky).
- REQ-013: The block SHALL have the port lock_loss_cnt, output, 8 bits: count of lock losses while in RUN, saturating at 255.
- REQ-014: The block SHALL have the port state, output, 3 bits: current FSM state encoding.

Function
- REQ-015: pll_locked SHALL pass through a 2-FF synchronizer (locked_s); raw rise at edge t is visible as locked_s at edge t+2.
- REQ-016: The FSM SHALL have the states OFF=0, RESET=1, WAIT_LOCK=2, STABLE=3, RUN=4, FAULT=5; all outputs SHALL be registered Moore outputs decoded from state.
- REQ-017: In OFF, pll_rst=1 and clk_ok=busy=fault=0; enable=1 SHALL cause a move to RESET, which clears the cycle counter and the retry counter.
- REQ-018: In RESET, pll_rst=1 and busy=1 for exactly RST_CYCLES cycles, then the FSM SHALL move to WAIT_LOCK with the counter cleared.
- REQ-019: In WAIT_LOCK, pll_rst=0 and busy=1; if locked_s=1 the FSM SHALL move to STABLE with the counter cleared.
- REQ-020: In WAIT_LOCK, after TIMEOUT_CYCLES cycles without lock, the FSM SHALL move to RESET with retry+1 if retry<MAX_RETRIES, else move to FAULT.
- REQ-021: In STABLE, pll_rst=0 and busy=1; after STABLE_CYCLES consecutive cycles with locked_s=1 the FSM SHALL move to RUN and clear retry.
- REQ-022: In STABLE, any cycle with locked_s=0 SHALL cause a return to WAIT_LOCK with the counter cleared and no retry increment.
- REQ-023: In RUN, clk_ok=1, busy=0 and pll_rst=0; locked_s=0 SHALL cause lock_loss_cnt to increment (saturating at 255) and the FSM to move to RESET, with clk_ok low from the next cycle.
- REQ-024: In FAULT, pll_rst=1, fault=1, busy=0 and clk_ok=0; the FSM SHALL hold this state until enable=0.
- REQ-025: enable=0 SHALL move the FSM to OFF on the next edge from any state; this has priority over timeout, lock and stable events in the same cycle.
- REQ-026: A lock loss coinciding with enable=0 in RUN SHALL still be counted.
- REQ-027: The cycle counter SHALL be 20 bits and SHALL NOT wrap: every terminal compare uses ==N-1 and the counter is cleared on every state change.
- REQ-028: lock_loss_cnt SHALL be cleared only by rst; it SHALL NOT be cleared by enable=0.

Reset
- REQ-029: rst=1 sampled at a refclk edge SHALL force state=OFF, pll_rst=1, clk_ok=0, busy=0, fault=0, lock_loss_cnt=0, counters=0 and synchronizer FFs=0.
- REQ-030: rst SHALL take priority over all other inputs, including mid-sequence and in FAULT.

Verification (RST_CYCLES=4, STABLE_CYCLES=8, TIMEOUT_CYCLES=32, MAX_RETRIES=2)
- REQ-031: Nominal: enable=1 at edge 0, pll_locked=1 from edge 10 -> pll_rst high for edges 1-4, locked_s=1 at edge 12, STABLE at edge 13, clk_ok=1 at edge 21.
- REQ-032: Timeout: pll_locked held 0 -> three RESET pulses of 4 cycles each separated by 32-cycle waits, then fault=1 and pll_rst=1; enable=0 -> OFF and fault=0 next cycle.
- REQ-033: Glitch in STABLE: pll_locked low for 3 cycles mid-STABLE -> return to WAIT_LOCK, retry unchanged, clk_ok=1 reached 8 cycles after relock.
- REQ-034: Lock loss in RUN: drop pll_locked -> clk_ok=0 within 3 cycles, lock_loss_cnt 0->1, new 4-cycle pll_rst pulse; 300 losses -> lock_loss_cnt=255.
- REQ-035: Priority: enable=0 coincident with the STABLE terminal cycle -> OFF, clk_ok never asserted; rst asserted in WAIT_LOCK -> all outputs at reset values next edge.
